dma_scheduler: RTL and testbench

DMA_SCHEDULER -- requirements
Module: dma_scheduler

---
 rtl/dma_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dma_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_scheduler.sv
// dma_scheduler: round-robin two-requester descriptor queue feeding one DMA master.
// Optional watchdog (WAIT-cycle limit, ERR state, sticky err_o) enabled by DMA_SCHED_TIMEOUT_EN.
module dma_scheduler #(
  parameter int unsigned QDEPTH  = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_src,
  input  logic [31:0] req0_dst,
  input  logic [31:0] req0_qty,
  input  logic [31:0] req1_src,
  input  logic [31:0] req1_dst,
  input  logic [31:0] req1_qty,
  output logic        dma_en_o,
  output logic [31:0] src_addr_o,
  output logic [31:0] dst_addr_o,
  output logic [31:0] data_qty_o,
  input  logic        dma_fin_i,
  output logic [1:0]  irq_o,
  input  logic [1:0]  irq_clr_i,
  output logic        busy_o,
  output logic        err_o
);
  localparam int unsigned AW = $clog2(QDEPTH);

`ifdef DMA_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_DONE, ST_ERR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_DONE} state_t;
`endif

  state_t          state, state_nxt;
  logic [31:0]     q_src [QDEPTH];
  logic [31:0]     q_dst [QDEPTH];
  logic [31:0]     q_qty [QDEPTH];
  logic [QDEPTH-1:0] q_id;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, push, pop, push_id;
  logic            last_gnt;
  logic            gnt0, gnt1;
  logic            act_id;
  logic [1:0]      irq_set;

  // Occupancy can only reach QDEPTH (a power of two), so the MSB alone flags full.
  assign full = count[AW];

  assign gnt0 = req0_valid & (~req1_valid | last_gnt);
  assign gnt1 = req1_valid & (~req0_valid | ~last_gnt);
  assign req0_ready = rstn & ~full & gnt0;
  assign req1_ready = rstn & ~full & gnt1;
  assign push    = req0_ready | req1_ready;
  assign push_id = req1_ready;
  assign pop     = (state == ST_LAUNCH);
  assign busy_o  = (state != ST_IDLE) | (count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_gnt <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_gnt <= push_id;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr] <= push_id ? req1_src : req0_src;
      q_dst[wr_ptr] <= push_id ? req1_dst : req0_dst;
      q_qty[wr_ptr] <= push_id ? req1_qty : req0_qty;
      q_id[wr_ptr]  <= push_id;
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt;
`endif

  always_comb begin
    state_nxt = state;
    dma_en_o  = 1'b0;
    irq_set   = 2'b00;
    case (state)
      ST_IDLE:   if (count != '0) state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        dma_en_o  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (dma_fin_i) state_nxt = ST_DONE;
`ifdef DMA_SCHED_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT - 16'd1) state_nxt = ST_ERR;
`endif
      end
      ST_DONE: begin
        irq_set   = act_id ? 2'b10 : 2'b01;
        state_nxt = (count != '0) ? ST_LAUNCH : ST_IDLE;
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      ST_ERR:    state_nxt = ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Descriptor is captured on the edge entering LAUNCH so the fields are valid
  // alongside the start pulse; the head itself is retired on the edge leaving LAUNCH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_addr_o <= '0;
      dst_addr_o <= '0;
      data_qty_o <= '0;
      act_id     <= 1'b0;
      irq_o      <= '0;
    end else begin
      if (state_nxt == ST_LAUNCH) begin
        src_addr_o <= q_src[rd_ptr];
        dst_addr_o <= q_dst[rd_ptr];
        data_qty_o <= q_qty[rd_ptr];
        act_id     <= q_id[rd_ptr];
      end
      irq_o <= (irq_o & ~irq_clr_i) | irq_set;
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 16'd1 : '0;
      if (state_nxt == ST_ERR) err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dma_scheduler.sv
// Self-checking bench for dma_scheduler: cycle-level queue/arbiter model plus directed literal checks.
module tb_dma_scheduler;
  localparam int unsigned QD = 4;
`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_CYC = 100;
`else
  localparam int unsigned TMO_CYC = 65535;
`endif
  localparam logic [15:0] TMO = 16'(TMO_CYC);

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_src, req0_dst, req0_qty, req1_src, req1_dst, req1_qty;
  logic        dma_en_o, dma_fin_i, busy_o, err_o;
  logic [31:0] src_addr_o, dst_addr_o, data_qty_o;
  logic [1:0]  irq_o, irq_clr_i;

  dma_scheduler #(.QDEPTH(QD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_src(req0_src), .req0_dst(req0_dst), .req0_qty(req0_qty),
    .req1_src(req1_src), .req1_dst(req1_dst), .req1_qty(req1_qty),
    .dma_en_o(dma_en_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .data_qty_o(data_qty_o), .dma_fin_i(dma_fin_i), .irq_o(irq_o),
    .irq_clr_i(irq_clr_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] src, dst, qty;
    logic        id;
  } desc_t;

  desc_t       mq[$];
  desc_t       cur, nd;
  int unsigned stage;   // 0 free, 1 issuing start, 2 job in flight, 3 completing, 4 watchdog fired
  int unsigned m_wait;  // cycles already spent in flight
  logic        m_last, m_err;
  logic [1:0]  m_irq, set;
  int unsigned sz;
  logic        full, g0, g1, e_r0, e_r1;

  task automatic model_reset();
    mq.delete();
    cur = '0; stage = 0; m_wait = 0;
    m_last = 1'b1; m_err = 1'b0; m_irq = 2'b00;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      model_reset();
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      chk("rst_dma_en", 32'(dma_en_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_irq", 32'(irq_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_src", src_addr_o, 0);
      chk("rst_qty", data_qty_o, 0);
    end else begin
      sz   = mq.size();
      full = (sz == QD);
      g0   = req0_valid && (!req1_valid || m_last);
      g1   = req1_valid && (!req0_valid || !m_last);
      e_r0 = g0 && !full;
      e_r1 = g1 && !full;
      chk("ready0", 32'(req0_ready), 32'(e_r0));
      chk("ready1", 32'(req1_ready), 32'(e_r1));
      chk("dma_en", 32'(dma_en_o), 32'(stage == 1));
      chk("busy", 32'(busy_o), 32'(stage != 0 || sz != 0));
      chk("irq", 32'(irq_o), 32'(m_irq));
      chk("err", 32'(err_o), 32'(m_err));
      chk("src", src_addr_o, cur.src);
      chk("dst", dst_addr_o, cur.dst);
      chk("qty", data_qty_o, cur.qty);
      // advance the model by one clock
      set = (stage == 3) ? (cur.id ? 2'b10 : 2'b01) : 2'b00;
      case (stage)
        0: if (sz != 0) begin cur = mq[0]; stage = 1; end
        1: begin void'(mq.pop_front()); stage = 2; m_wait = 0; end
        2: begin
          if (dma_fin_i) stage = 3;
`ifdef DMA_SCHED_TIMEOUT_EN
          else if (m_wait == TMO_CYC - 1) begin stage = 4; m_err = 1'b1; end
          else m_wait++;
`endif
        end
        3: if (sz != 0) begin cur = mq[0]; stage = 1; end else stage = 0;
        default: stage = 0;
      endcase
      if (e_r0 || e_r1) begin
        nd.src = e_r1 ? req1_src : req0_src;
        nd.dst = e_r1 ? req1_dst : req0_dst;
        nd.qty = e_r1 ? req1_qty : req0_qty;
        nd.id  = e_r1;
        mq.push_back(nd);
        m_last = e_r1;
      end
      m_irq = (m_irq & ~irq_clr_i) | set;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    step(); rstn = 1'b0;
    step(); rstn = 1'b1;
  endtask

  // One req0 job from an idle, empty scheduler with irq_o clear; clr_done is driven during DONE.
  task automatic job0(input logic [31:0] s, input logic [31:0] d, input logic [31:0] q,
                      input logic [1:0] clr_done);
    step();
    req0_valid = 1'b1; req0_src = s; req0_dst = d; req0_qty = q;
    step();
    req0_valid = 1'b0;
    @(negedge clk); chk("lat_cyc1_en", 32'(dma_en_o), 0);
    step();
    @(negedge clk);
    chk("lat_cyc2_en", 32'(dma_en_o), 1);
    chk("lat_src", src_addr_o, s);
    chk("lat_dst", dst_addr_o, d);
    chk("lat_qty", data_qty_o, q);
    step(); dma_fin_i = 1'b1;
    @(negedge clk); chk("wait_en", 32'(dma_en_o), 0);
    step(); dma_fin_i = 1'b0; irq_clr_i = clr_done;
    @(negedge clk); chk("done_irq", 32'(irq_o), 0);
    step(); irq_clr_i = 2'b01;
    @(negedge clk); chk("irq_set", 32'(irq_o), 32'h1);
    step(); irq_clr_i = 2'b00;
    @(negedge clk); chk("irq_cleared", 32'(irq_o), 0);
  endtask

  logic [6:0]  exp_r0 = 7'b0010101;
  logic [6:0]  exp_r1 = 7'b0001010;
  int unsigned en_cnt;

  initial begin
    rstn = 1'b0; dma_fin_i = 1'b0; irq_clr_i = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_src = 0; req0_dst = 0; req0_qty = 0;
    req1_src = 0; req1_dst = 0; req1_qty = 0;
    repeat (2) @(negedge clk);
    chk("lit_rst_ready0", 32'(req0_ready), 0);
    chk("lit_rst_busy", 32'(busy_o), 0);
    step(); req0_valid = 1'b0; rstn = 1'b1;

    // basic latency, then set-over-clear on the same irq bit
    job0(32'h1000, 32'h2000, 32'h10, 2'b00);
    job0(32'h3000, 32'h4000, 32'h0, 2'b01);

    // both requesters streaming: alternation from requester 0, then full
    reset_pulse();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_src = 32'hA0; req0_dst = 32'hB0; req0_qty = 32'h5;
    req1_src = 32'hA1; req1_dst = 32'hB1; req1_qty = 32'h7;
    en_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("rr_ready0", 32'(req0_ready), 32'(exp_r0[i]));
      chk("rr_ready1", 32'(req1_ready), 32'(exp_r1[i]));
      en_cnt += 32'(dma_en_o);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      dma_fin_i = ((k % 20) == 19);
      @(negedge clk);
      en_cnt += 32'(dma_en_o);
      step();
    end
    dma_fin_i = 1'b0;
    @(negedge clk);
    chk("drain_pulses", en_cnt, 5);
    chk("drain_busy", 32'(busy_o), 0);
    chk("drain_irq", 32'(irq_o), 32'h3);

    // reset while in flight with two jobs queued
    step();
    req1_valid = 1'b1; req1_src = 32'hC0; req1_dst = 32'hD0; req1_qty = 32'h9;
    repeat (3) step();
    req1_valid = 1'b0;
    step(); rstn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_irq", 32'(irq_o), 0);
    chk("midrst_src", src_addr_o, 0);
    chk("midrst_en", 32'(dma_en_o), 0);
    step(); step(); rstn = 1'b1;
    en_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      en_cnt += 32'(dma_en_o);
      step();
    end
    chk("midrst_no_pulse", en_cnt, 0);

`ifdef DMA_SCHED_TIMEOUT_EN
    // watchdog: no completion, job dropped, next job still launched
    reset_pulse();
    req0_valid = 1'b1; req0_src = 32'hE0; req0_dst = 32'hF0; req0_qty = 32'h3;
    step(); step();
    req0_valid = 1'b0;
    for (int k = 0; k < 300 && !err_o; k++) step();
    @(negedge clk);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_irq", 32'(irq_o), 0);
    en_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      en_cnt += 32'(dma_en_o);
    end
    chk("tmo_next_launch", en_cnt, 1);
    step();
`endif

    // randomized traffic against the model
    reset_pulse();
    for (int i = 0; i < 4000; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_src = $urandom(); req0_dst = $urandom(); req0_qty = $urandom_range(0, 3);
      req1_src = $urandom(); req1_dst = $urandom(); req1_qty = $urandom();
      dma_fin_i = ($urandom_range(0, 7) == 0);
      irq_clr_i = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rstn = ($urandom_range(0, 599) != 0);
      step();
    end
    rstn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; dma_fin_i = 1'b0; irq_clr_i = 2'b00;
    step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
